// File: rtl/uart_tx_mmio_if.sv
// ============================================================================
// Module      : uart_tx_mmio_if
// Description : CPU/RAM-style byte bus as seen by the memory-mapped UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_mmio_if;
    logic [15:0] addr;
    logic [7:0]  di;
    logic        we;
    logic [7:0]  dout;      // the CPU-side "do" bus; do is a reserved word
    logic        rd_valid;

    modport master (
        output addr,
        output di,
        output we,
        input  dout,
        input  rd_valid
    );

    modport slave (
        input  addr,
        input  di,
        input  we,
        output dout,
        output rd_valid
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter with a byte TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx_o,
    output logic          irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] c_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    localparam logic [1:0] c_REG_TXDATA = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;
    logic [7:0]    dout_q, dout_d;
    logic          rd_valid_q, rd_valid_d;

    logic          w_hit;
    logic          w_rd;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_status_rd;
    logic [7:0]    w_rd_data;
    logic [7:0]    w_head;

    always_comb begin
        w_hit       = (bus.addr[15:2] == BASE_ADDR[15:2]);
        w_rd        = w_hit & ~bus.we;
        w_full      = (count_q == c_CNT_FULL);
        w_empty     = (count_q == '0);
        w_busy      = (state_q != c_ST_IDLE);
        w_push      = w_hit & bus.we & (bus.addr[1:0] == c_REG_TXDATA);
        w_push_ok   = w_push & ~w_full;
        w_status_rd = w_rd & (bus.addr[1:0] == c_REG_STATUS);
        w_head      = mem_q[rd_ptr_q];
    end

    // Register read mux; status reports pre-edge flags.
    always_comb begin
        w_rd_data = 8'h00;
        case (bus.addr[1:0])
            c_REG_STATUS: w_rd_data = {4'b0000, overflow_q, w_busy, w_empty, w_full};
            c_REG_COUNT:  w_rd_data = 8'(count_q);
            default:      w_rd_data = 8'h00;
        endcase
        dout_d     = w_rd ? w_rd_data : dout_q;
        rd_valid_d = w_rd;
    end

    // Serialiser FSM; a pop is requested from IDLE or at the end of STOP.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    state_d = c_ST_START;
                    div_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            c_ST_START: begin
                if (div_q == c_DIV_LAST) begin
                    state_d = c_ST_DATA;
                    div_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            c_ST_DATA: begin
                if (div_q == c_DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = c_ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                if (div_q == c_DIV_LAST) begin
                    div_d = '0;
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        state_d = c_ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = c_ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A fresh overflow in the same cycle as a STATUS read must survive the clear.
        overflow_d = (overflow_q & ~w_status_rd) | (w_push & w_full);
        irq_d      = (count_d == '0) & (state_d == c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= bus.di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= c_ST_IDLE;
            div_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            irq_q      <= 1'b1;
            dout_q     <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
    assign tx_o         = tx_q;
    assign irq_o        = irq_q;

endmodule

`default_nettype wire
